// File: rtl/nes_pxl_palette_pipe.sv
// Pixel-composition stage: resolves background/sprite priority, addresses the
// palette ROM, registers the returned colour index and keeps the video strobes
// and sprite-zero-hit flag aligned with the two-stage pixel pipeline.
module nes_pxl_palette_pipe #(
  parameter logic [5:0] BLANK_IDX = 6'h0F,
  parameter logic [5:0] GREY_MASK = 6'h30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vis_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] bg_color,
  input  logic [1:0] bg_pal,
  input  logic       sp_en,
  input  logic [1:0] sp_color,
  input  logic [1:0] sp_pal,
  input  logic       sp_prio,
  input  logic       sp_zero,
  input  logic       greyscale,
  output logic [4:0] pal_addr,
  input  logic [7:0] pal_dout,
  output logic [5:0] col_idx,
  output logic       vis_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       spr0_hit
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned COL_W  = 6;

  // Stage-1 registers
  logic [ADDR_W-1:0] r_pal_addr;
  logic              r_vis1;
  logic              r_hs1;
  logic              r_vs1;
  logic              r_grey1;
  logic              r_vs_prev;
  logic              r_spr0;

  // Stage-2 registers
  logic [COL_W-1:0]  r_col_idx;
  logic              r_vis2;
  logic              r_hs2;
  logic              r_vs2;

  // Combinational decode
  logic              w_bg_op;
  logic              w_sp_op;
  logic              w_sp_win;
  logic [ADDR_W-1:0] w_addr;
  logic              w_vs_rise;
  logic              w_hit;
  logic [COL_W-1:0]  w_col;
  logic              w_pal_unused;

  // Palette bits above the 6-bit colour index carry no meaning here
  assign w_pal_unused = ^pal_dout[7:6];

  // Priority/transparency resolution and sprite-zero qualification
  always_comb begin
    w_bg_op   = 1'b0;
    w_sp_op   = 1'b0;
    w_sp_win  = 1'b0;
    w_addr    = '0;
    w_vs_rise = 1'b0;
    w_hit     = 1'b0;

    w_bg_op   = (bg_color != 2'b00);
    w_sp_op   = sp_en && (sp_color != 2'b00);
    w_sp_win  = w_sp_op && (!w_bg_op || !sp_prio);

    if (w_sp_win) begin
      w_addr = {1'b1, sp_pal, sp_color};
    end else if (w_bg_op) begin
      w_addr = {1'b0, bg_pal, bg_color};
    end

    w_vs_rise = vsync_in && !r_vs_prev;
    w_hit     = vis_in && sp_zero && w_bg_op && w_sp_op;
  end

  // Colour index for stage 2: blank outside the active area, greyscale mask inside
  always_comb begin
    w_col = BLANK_IDX;
    if (r_vis1) begin
      w_col = r_grey1 ? (pal_dout[COL_W-1:0] & GREY_MASK) : pal_dout[COL_W-1:0];
    end
  end

  // Stage 1: palette address, strobe/greyscale copies, sticky sprite-zero hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pal_addr <= '0;
      r_vis1     <= 1'b0;
      r_hs1      <= 1'b0;
      r_vs1      <= 1'b0;
      r_grey1    <= 1'b0;
      r_vs_prev  <= 1'b0;
      r_spr0     <= 1'b0;
    end else begin
      r_pal_addr <= w_addr;
      r_vis1     <= vis_in;
      r_hs1      <= hsync_in;
      r_vs1      <= vsync_in;
      r_grey1    <= greyscale;
      r_vs_prev  <= vsync_in;
      // A new frame clears the flag even if the same pixel would set it
      if (w_vs_rise) begin
        r_spr0 <= 1'b0;
      end else if (w_hit) begin
        r_spr0 <= 1'b1;
      end
    end
  end

  // Stage 2: registered colour index and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_idx <= BLANK_IDX;
      r_vis2    <= 1'b0;
      r_hs2     <= 1'b0;
      r_vs2     <= 1'b0;
    end else begin
      r_col_idx <= w_col;
      r_vis2    <= r_vis1;
      r_hs2     <= r_hs1;
      r_vs2     <= r_vs1;
    end
  end

  assign pal_addr  = r_pal_addr;
  assign col_idx   = r_col_idx;
  assign vis_out   = r_vis2;
  assign hsync_out = r_hs2;
  assign vsync_out = r_vs2;
  assign spr0_hit  = r_spr0;

endmodule

// File: tb/tb_nes_pxl_palette_pipe.sv
// Self-checking bench for the palette pipeline: a pixel-level reference model
// plus directed literal checks, then a randomized pixel stream.
module tb_nes_pxl_palette_pipe;

  typedef struct packed {
    logic       vis;
    logic       hs;
    logic       vs;
    logic [1:0] bgc;
    logic [1:0] bgp;
    logic       spe;
    logic [1:0] spc;
    logic [1:0] spp;
    logic       pri;
    logic       sz;
    logic       grey;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  pix_t       cur = '0;
  logic [7:0] rom [32];
  logic [4:0] pal_addr;
  logic [7:0] pal_dout;
  logic [5:0] col_idx;
  logic       vis_out, hsync_out, vsync_out, spr0_hit;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pixels currently held in the two stages
  pix_t m1, m2;
  bit   m1_valid, m2_valid;
  bit   m_spr0;
  bit   m_vs_prev;

  always #5 clk = ~clk;

  assign pal_dout = rom[pal_addr];

  nes_pxl_palette_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vis_in    (cur.vis),
    .hsync_in  (cur.hs),
    .vsync_in  (cur.vs),
    .bg_color  (cur.bgc),
    .bg_pal    (cur.bgp),
    .sp_en     (cur.spe),
    .sp_color  (cur.spc),
    .sp_pal    (cur.spp),
    .sp_prio   (cur.pri),
    .sp_zero   (cur.sz),
    .greyscale (cur.grey),
    .pal_addr  (pal_addr),
    .pal_dout  (pal_dout),
    .col_idx   (col_idx),
    .vis_out   (vis_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .spr0_hit  (spr0_hit)
  );

  function automatic logic [4:0] exp_addr(input pix_t p);
    bit bo, so;
    bo = (p.bgc != 0);
    so = p.spe && (p.spc != 0);
    if (so && (!bo || p.pri == 1'b0)) return 5'(16 + 4 * int'(p.spp) + int'(p.spc));
    if (bo)                           return 5'(4 * int'(p.bgp) + int'(p.bgc));
    return 5'd0;
  endfunction

  function automatic logic [5:0] exp_col();
    logic [7:0] b;
    if (!m2_valid || !m2.vis) return 6'h0F;
    b = rom[exp_addr(m2)];
    if (m2.grey) return b[5:0] & 6'h30;
    return b[5:0];
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m1 = '0; m2 = '0;
    m1_valid = 0; m2_valid = 0;
    m_spr0 = 0; m_vs_prev = 0;
  endtask

  // Advance the model by one clock edge using the pixel presented at that edge
  task automatic model_step();
    bit qual;
    if (!rst_n) begin
      model_reset();
      return;
    end
    qual = cur.vis && cur.sz && (cur.bgc != 0) && cur.spe && (cur.spc != 0);
    if (cur.vs && !m_vs_prev) m_spr0 = 0;
    else if (qual)            m_spr0 = 1;
    m_vs_prev = cur.vs;
    m2 = m1; m2_valid = m1_valid;
    m1 = cur; m1_valid = 1;
  endtask

  // Single compare point: every DUT output against the model
  task automatic check_all();
    chk("pal_addr",  8'(pal_addr),  8'(m1_valid ? exp_addr(m1) : 5'd0));
    chk("col_idx",   8'(col_idx),   8'(exp_col()));
    chk("vis_out",   8'(vis_out),   8'(m2_valid & m2.vis));
    chk("hsync_out", 8'(hsync_out), 8'(m2_valid & m2.hs));
    chk("vsync_out", 8'(vsync_out), 8'(m2_valid & m2.vs));
    chk("spr0_hit",  8'(spr0_hit),  8'(m_spr0));
  endtask

  // Present one pixel for one clock, then compare on the falling edge
  task automatic cycle(input pix_t p);
    cur = p;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  function automatic pix_t mk(input bit vis, input bit vs, input logic [1:0] bgc,
                              input logic [1:0] bgp, input bit spe, input logic [1:0] spc,
                              input logic [1:0] spp, input bit pri, input bit sz,
                              input bit grey);
    pix_t p;
    p = '0;
    p.vis = vis; p.vs = vs; p.bgc = bgc; p.bgp = bgp; p.spe = spe;
    p.spc = spc; p.spp = spp; p.pri = pri; p.sz = sz; p.grey = grey;
    return p;
  endfunction

  function automatic pix_t rnd_pix();
    pix_t p;
    p = pix_t'($urandom);
    p.vis = ($urandom_range(0, 7) != 0);
    p.vs  = ($urandom_range(0, 15) == 0);
    p.sz  = ($urandom_range(0, 3) == 0);
    return p;
  endfunction

  initial begin
    pix_t p;
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
    rom[5'h00] = 8'h15;
    rom[5'h11] = 8'hFC;
    rom[5'h06] = 8'h5A;
    rom[5'h1E] = 8'hBA;
    model_reset();

    // Reset held: outputs at reset values, pal_addr stays 0
    cur = rnd_pix();
    cur.vis = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all();
      chk("rst_pal_addr", 8'(pal_addr), 8'h00);
    end
    cur = '0;
    rst_n = 1'b1;
    cycle('0);
    cycle('0);
    chk("rel_col_idx", 8'(col_idx), 8'h0F);
    chk("rel_vis_out", 8'(vis_out), 8'h00);

    // Backdrop path, including a transparent sprite with a non-zero palette
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("bd_addr", 8'(pal_addr), 8'h00);
    cycle(mk(1, 0, 0, 0, 1, 0, 3, 0, 0, 0));
    chk("bd_col", 8'(col_idx), 8'h15);
    chk("bd_sp_addr", 8'(pal_addr), 8'h00);

    // Priority: sprite in front, then behind
    cycle(mk(1, 0, 2, 1, 1, 1, 0, 0, 0, 0));
    chk("pri0_addr", 8'(pal_addr), 8'h11);
    cycle(mk(1, 0, 2, 1, 1, 1, 0, 1, 0, 0));
    chk("pri0_col", 8'(col_idx), 8'h3C);
    chk("pri1_addr", 8'(pal_addr), 8'h06);

    // Greyscale on a sprite pixel
    cycle(mk(1, 0, 0, 0, 1, 2, 3, 0, 0, 1));
    chk("pri1_col", 8'(col_idx), 8'h1A);
    chk("grey_addr", 8'(pal_addr), 8'h1E);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("grey_col", 8'(col_idx), 8'h30);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("blank_col", 8'(col_idx), 8'h0F);

    // Sprite-zero hit: set, held, cleared by a vsync rise
    cycle(mk(1, 0, 1, 0, 1, 1, 0, 1, 1, 0));
    chk("s0_set", 8'(spr0_hit), 8'h01);
    for (int i = 0; i < 3; i++) cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("s0_hold", 8'(spr0_hit), 8'h01);
    cycle(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("s0_clr", 8'(spr0_hit), 8'h00);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Qualifying pixel on the same clock as a vsync rise: clear wins
    cycle(mk(1, 1, 3, 2, 1, 3, 1, 0, 1, 0));
    chk("s0_coinc", 8'(spr0_hit), 8'h00);
    // vsync held high is not a new rise, so a hit now sets the flag
    cycle(mk(1, 1, 3, 2, 1, 3, 1, 0, 1, 0));
    chk("s0_vs_level", 8'(spr0_hit), 8'h01);

    // Alignment: eight distinct pixels with vis/hsync toggling mid-stream
    for (int i = 0; i < 8; i++) begin
      p = mk(i < 3 || i > 5, 0, 2'(i), 2'(i >> 1), 1'(i), 2'(i + 1), 2'(i >> 2), 0, 0, 0);
      p.hs = (i >= 2 && i <= 4);
      cycle(p);
    end

    // Asynchronous reset pulse in the middle of a line
    cycle(mk(1, 0, 1, 0, 1, 1, 0, 0, 1, 0));
    cycle(mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_spr0", 8'(spr0_hit), 8'h00);
    chk("arst_col",  8'(col_idx),  8'h0F);
    chk("arst_addr", 8'(pal_addr), 8'h00);
    chk("arst_vis",  8'(vis_out),  8'h00);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    chk("post_rst_col", 8'(col_idx), 8'h0F);
    cycle(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    chk("post_rst_col2", 8'(col_idx), 8'(rom[5'h05] & 8'h3F));

    // Randomized pixel stream
    for (int i = 0; i < 3000; i++) cycle(rnd_pix());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_pxl_palette_pipe.md
Name: nes_pxl_palette_pipe

Overview:
- Pixel-composition stage in the NES PPU video path.
- Takes the per-pixel background and sprite pattern outputs from the renderer and resolves priority and transparency.
- Drives the 5-bit address of the combinational palette ROM (ROM_PALETTE_SPRILO) and registers the ROM's color byte as a 6-bit NES color index for the RGB/VGA output stage.
- Also delays the sync/visible strobes to stay aligned with the pixel, and keeps the sticky sprite-zero-hit flag.

Parameters:
- BLANK_IDX, 6'h0F, NES color index driven while the pixel is not visible (black).
- GREY_MASK, 6'h30, mask ANDed onto the color index when greyscale is on.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vis_in  in  1  pixel is in the active area
- hsync_in  in  1  horizontal sync, aligned with vis_in
- vsync_in  in  1  vertical sync, aligned with vis_in
- bg_color  in  2  background pattern color; 0 = transparent
- bg_pal  in  2  background palette select
- sp_en  in  1  a sprite covers this pixel
- sp_color  in  2  sprite pattern color; 0 = transparent
- sp_pal  in  2  sprite palette select
- sp_prio  in  1  0 = sprite in front, 1 = sprite behind opaque background
- sp_zero  in  1  covering sprite is OAM sprite 0
- greyscale  in  1  PPUMASK greyscale bit
- pal_addr  out  5  registered address to the palette ROM
- pal_dout  in  8  palette ROM data, combinational from pal_addr
- col_idx  out  6  NES color index to the RGB stage
- vis_out  out  1  vis_in delayed by 2
- hsync_out  out  1  hsync_in delayed by 2
- vsync_out  out  1  vsync_in delayed by 2
- spr0_hit  out  1  sticky sprite-zero hit flag

Behaviour:
- Reset (rst_n low, asynchronous) clears all registers:
  - pal_addr=0, col_idx=BLANK_IDX;
  - vis_out, hsync_out, vsync_out = 0;
  - spr0_hit=0;
  - internal stage-1 vis/sync/greyscale copies = 0.
  - Reset asserted mid-frame discards both pipeline stages at once; the first valid output follows 2 clocks after rst_n deasserts.
- Stage 1 (at each clk rising edge):
  - bg_op = (bg_color != 0); sp_op = sp_en and (sp_color != 0).
  - Neither opaque: pal_addr = 5'h00 (universal backdrop). The backdrop is never taken from a sprite palette.
  - Only the sprite opaque: pal_addr = {1, sp_pal, sp_color}.
  - Only the background opaque: pal_addr = {0, bg_pal, bg_color}.
  - Both opaque: sp_prio=0 selects the sprite address, sp_prio=1 selects the background address.
  - vis, hsync, vsync and greyscale are registered into stage-1 copies.
- Stage 2 (at each clk rising edge):
  - Stage-1 vis=1: col_idx = pal_dout[5:0], ANDed with GREY_MASK when stage-1 greyscale=1. pal_dout[7:6] is ignored.
  - Stage-1 vis=0: col_idx = BLANK_IDX, with no greyscale applied.
  - vis_out, hsync_out and vsync_out take the stage-1 copies.
- Total latency is 2 clocks, input to col_idx, for pixel data and strobes alike. Throughput is one pixel per clock with no stall.
- pal_addr is computed every clock, including outside the visible area; only col_idx is forced to BLANK_IDX.
- Sprite-zero hit:
  - Set in stage 1 when vis_in=1, sp_zero=1, bg_op and sp_op; sp_prio does not matter.
  - Sticky; becomes visible on spr0_hit one clock after the qualifying pixel.
  - Cleared on a rising edge of vsync_in (edge detect against the previous vsync_in sample).
  - Set and rising edge in the same clock: clear wins.
- Not in this block: left-8-pixel clipping and rendering enables. Upstream forces bg_color/sp_en to 0 where required.

Test Plan:
- Reset: hold rst_n=0, then release with vis_in=0 -> col_idx=6'h0F and all strobes 0; pal_addr=0 throughout reset.
- Backdrop path: vis_in=1, bg_color=0, sp_en=0 -> pal_addr=5'h00 after 1 clk; col_idx=6'h15 after 2 clks. Also with sp_en=1, sp_color=0, sp_pal=2'b11 -> still pal_addr=5'h00.
- Priority:
  - bg_pal=1, bg_color=2, sp_pal=0, sp_color=1, sp_prio=0 -> pal_addr=5'h11, col_idx=6'h3C.
  - Same inputs with sp_prio=1 -> pal_addr=5'h06, col_idx=6'h1A.
- Greyscale: sp_pal=3, sp_color=2, greyscale=1 -> pal_addr=5'h1E; col_idx=6'h3A&6'h30=6'h30.
- Alignment: stream of 8 distinct pixels, toggling hsync_in/vis_in mid-stream -> col_idx and all strobes shifted exactly 2 clks; blanked pixels give 6'h0F.
- Sprite-zero hit:
  - sp_zero=1 with both layers opaque -> spr0_hit=1 next clk, held over later transparent pixels, cleared after a vsync_in rise.
  - Qualifying pixel coincident with a vsync rise -> spr0_hit stays 0.
  - rst_n pulse mid-line -> spr0_hit=0 and col_idx=6'h0F immediately (asynchronous).
